regbank_mp: RTL

- Multi-port, parametrised register bank; successor to the single-write, fully-exposed register array.
- Provides NUM_WR write ports with byte enables and NUM_RD registered read ports with a one-cycle read latency.
- After reset, a hardware clear sequencer zeroes every entry, so no wide reset fan-out is needed.
- Used as the CPU general-purpose register file and as a scratch bank for peripherals.

---
 rtl/regbank_mp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regbank_mp.sv
// regbank_mp: multi-port register bank with byte-enabled writes, registered reads and a
// post-reset clear sequencer. Optional macro REGBANK_BYPASS_EN forwards same-cycle writes to reads.
module regbank_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32,
    parameter int SIZE       = 1 << ADDR_WIDTH,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_WR-1:0]                i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [NUM_WR*(WORD_WIDTH/8)-1:0] i_wr_be,
    input  logic [NUM_WR*WORD_WIDTH-1:0]     i_wr_data,
    input  logic [NUM_RD-1:0]                i_rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     i_rd_addr,
    output logic [NUM_RD*WORD_WIDTH-1:0]     o_rd_data,
    output logic [NUM_RD-1:0]                o_rd_valid,
    output logic                             o_busy
);
    localparam int NB     = WORD_WIDTH / 8;
    localparam int LAST_I = SIZE - 1;
    localparam int SIZE_I = SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST_I[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   SIZE_W    = SIZE_I[ADDR_WIDTH:0];

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDR_WIDTH-1:0]        r_clr_cnt;
    logic [ADDR_WIDTH-1:0]        w_clr_cnt_nxt;
    logic                         r_busy;
    logic                         w_busy_nxt;
    logic [WORD_WIDTH-1:0]        r_mem [SIZE];
    logic [WORD_WIDTH-1:0]        w_rd_word [NUM_RD];
    logic [NUM_RD*WORD_WIDTH-1:0] r_rd_data;
    logic [NUM_RD-1:0]            r_rd_valid;

    // Addresses may exceed SIZE when SIZE is not a power of two.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < SIZE_W);
    endfunction

    // State register for the clear sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic: walk every entry once, then stay in READY until reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy_nxt    = r_busy;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = READY;
                    w_clr_cnt_nxt = '0;
                    w_busy_nxt    = 1'b0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                    w_busy_nxt    = 1'b1;
                end
            end
            READY: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_cnt_nxt = '0;
                w_busy_nxt    = 1'b1;
            end
        endcase
    end

    // Storage: clear sweep, or byte-enabled writes where later ports override earlier ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (i_wr_en[k] && i_wr_be[k*NB+b] &&
                            in_range(i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            r_mem[i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <=
                                i_wr_data[k*WORD_WIDTH + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read word selection, with optional same-cycle write forwarding.
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            w_rd_word[j] = '0;
            if (in_range(i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_rd_word[j] = r_mem[i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            end else begin
                w_rd_word[j] = '0;
            end
`ifdef REGBANK_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                for (int b = 0; b < NB; b++) begin
                    w_rd_word[j][b*8 +: 8] =
                        (i_wr_en[k] && i_wr_be[k*NB+b] &&
                         in_range(i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
                         (i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == i_rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]))
                        ? i_wr_data[k*WORD_WIDTH + b*8 +: 8]
                        : w_rd_word[j][b*8 +: 8];
                end
            end
`endif
        end
    end

    // Registered read ports; data holds between requests, zero while clearing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            for (int j = 0; j < NUM_RD; j++) begin
                if (i_rd_en[j]) begin
                    r_rd_data[j*WORD_WIDTH +: WORD_WIDTH] <= (r_state == READY) ? w_rd_word[j] : '0;
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = r_busy;

endmodule
